pc_delay_slot_unit: RTL

Parametrised program-counter unit for the multi-cycle MIPS core, replacing the two-phase PC.
- Sequences FETCH/EXEC internally and honours a memory stall.
- Computes branch and jump targets from decoded fields.
- Implements the architectural branch delay slot: the instruction after a taken branch or jump always executes before the redirect.
- Drives the fetch address, the link address for the AL-type instructions, and the halt/error status seen by the top level.

---
 rtl/pc_pkg.sv | 25 ++
 rtl/pc_delay_slot_unit_if.sv | 33 +++
 rtl/pc_target_calc.sv | 57 +++++
 rtl/pc_delay_slot_unit.sv | 128 ++++++++++++
 4 files changed

// File: rtl/pc_pkg.sv
// Shared types and defaults for the program-counter unit.
//   ctrl_kind_t : control class of the instruction in EXEC
//   pc_state_t  : sequencer state
package pc_pkg;

  localparam int unsigned OFFSET_W = 16;
  localparam int unsigned INDEX_W  = 26;

  localparam logic [31:0] DEFAULT_RESET_VECTOR = 32'hBFC0_0000;
  localparam logic [31:0] DEFAULT_HALT_ADDR    = 32'h0000_0000;

  typedef enum logic [1:0] {
    NONE     = 2'd0,
    BRANCH   = 2'd1,
    JUMP_IMM = 2'd2,
    JUMP_REG = 2'd3
  } ctrl_kind_t;

  typedef enum logic [1:0] {
    FETCH  = 2'd0,
    EXEC   = 2'd1,
    HALTED = 2'd2
  } pc_state_t;

endpackage

// File: rtl/pc_delay_slot_unit_if.sv
// Core <-> PC unit bundle.
//   master : core side, drives stall and decoded control fields
//   slave  : PC unit, drives pc, phase strobes, link address and status
interface pc_delay_slot_unit_if #(
  parameter int unsigned ADDR_W = 32
);
  import pc_pkg::*;

  logic                  stall;
  ctrl_kind_t            ctrl_kind;
  logic                  cond_true;
  logic [OFFSET_W-1:0]   offset;
  logic [INDEX_W-1:0]    instr_index;
  logic [ADDR_W-1:0]     reg_target;
  logic [ADDR_W-1:0]     pc;
  logic                  fetch;
  logic                  exec;
  logic [ADDR_W-1:0]     link_addr;
  logic                  in_delay_slot;
  logic                  halt;
  logic                  addr_error;

  modport master (
    output stall, ctrl_kind, cond_true, offset, instr_index, reg_target,
    input  pc, fetch, exec, link_addr, in_delay_slot, halt, addr_error
  );

  modport slave (
    input  stall, ctrl_kind, cond_true, offset, instr_index, reg_target,
    output pc, fetch, exec, link_addr, in_delay_slot, halt, addr_error
  );

endinterface

// File: rtl/pc_target_calc.sv
// Combinational next-address math for the instruction in EXEC.
//   in : pc, ctrl_kind, cond_true, offset, instr_index, reg_target
//   out: pc4 (pc+4, wraps), target, taken, misaligned (JR/JALR target not word aligned)
module pc_target_calc
  import pc_pkg::*;
#(
  parameter int unsigned ADDR_W = 32
) (
  input  logic [ADDR_W-1:0]   pc,
  input  ctrl_kind_t          ctrl_kind,
  input  logic                cond_true,
  input  logic [OFFSET_W-1:0] offset,
  input  logic [INDEX_W-1:0]  instr_index,
  input  logic [ADDR_W-1:0]   reg_target,
  output logic [ADDR_W-1:0]   pc4,
  output logic [ADDR_W-1:0]   target,
  output logic                taken,
  output logic                misaligned
);

  logic [ADDR_W-1:0] branch_off;
  logic [ADDR_W-1:0] jump_imm;

  assign pc4        = pc + ADDR_W'(4);
  // Sign-extended word offset
  assign branch_off = {{(ADDR_W-OFFSET_W-2){offset[OFFSET_W-1]}}, offset, 2'b00};

  // J/JAL keep the upper region bits of the delay-slot address
  if (ADDR_W > 28) begin : g_region
    assign jump_imm = {pc4[ADDR_W-1:28], instr_index, 2'b00};
  end else begin : g_flat
    assign jump_imm = ADDR_W'({instr_index, 2'b00});
  end

  always_comb begin
    target = pc4;
    taken  = 1'b0;
    case (ctrl_kind)
      BRANCH: begin
        target = pc4 + branch_off;
        taken  = cond_true;
      end
      JUMP_IMM: begin
        target = jump_imm;
        taken  = 1'b1;
      end
      JUMP_REG: begin
        target = reg_target;
        taken  = 1'b1;
      end
      default: ;
    endcase
  end

  assign misaligned = (ctrl_kind == JUMP_REG) && (reg_target[1:0] != 2'b00);

endmodule

// File: rtl/pc_delay_slot_unit.sv
// Program counter with FETCH/EXEC sequencing and one architectural delay slot.
//   clk, reset : clock, synchronous active-high reset
//   bus        : pc_delay_slot_unit_if.slave (stall, control fields in; pc/status out)
module pc_delay_slot_unit
  import pc_pkg::*;
#(
  parameter int unsigned ADDR_W       = 32,
  parameter logic [31:0] RESET_VECTOR = DEFAULT_RESET_VECTOR,
  parameter logic [31:0] HALT_ADDR    = DEFAULT_HALT_ADDR
) (
  input logic                  clk,
  input logic                  reset,
  pc_delay_slot_unit_if.slave  bus
);

  localparam logic [ADDR_W-1:0] RV = ADDR_W'(RESET_VECTOR);
  localparam logic [ADDR_W-1:0] HA = ADDR_W'(HALT_ADDR);

  pc_state_t         state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] pending_target_q, pending_target_d;
  logic              pending_valid_q, pending_valid_d;
  logic              in_ds_q, in_ds_d;
  logic              halt_q, halt_d;
  logic              err_q, err_d;
  logic              fetch_q, fetch_d;
  logic              exec_q, exec_d;

  logic [ADDR_W-1:0] pc4;
  logic [ADDR_W-1:0] target;
  logic              taken;
  logic              misaligned;

  pc_target_calc #(.ADDR_W(ADDR_W)) u_calc (
    .pc          (pc_q),
    .ctrl_kind   (bus.ctrl_kind),
    .cond_true   (bus.cond_true),
    .offset      (bus.offset),
    .instr_index (bus.instr_index),
    .reg_target  (bus.reg_target),
    .pc4         (pc4),
    .target      (target),
    .taken       (taken),
    .misaligned  (misaligned)
  );

  // State and architectural registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q          <= FETCH;
      pc_q             <= RV;
      pending_target_q <= '0;
      pending_valid_q  <= 1'b0;
      in_ds_q          <= 1'b0;
      halt_q           <= 1'b0;
      err_q            <= 1'b0;
      fetch_q          <= 1'b1;
      exec_q           <= 1'b0;
    end else begin
      state_q          <= state_d;
      pc_q             <= pc_d;
      pending_target_q <= pending_target_d;
      pending_valid_q  <= pending_valid_d;
      in_ds_q          <= in_ds_d;
      halt_q           <= halt_d;
      err_q            <= err_d;
      fetch_q          <= fetch_d;
      exec_q           <= exec_d;
    end
  end

  // Next-state and register updates; stall holds everything
  always_comb begin
    state_d          = state_q;
    pc_d             = pc_q;
    pending_target_d = pending_target_q;
    pending_valid_d  = pending_valid_q;
    in_ds_d          = in_ds_q;
    halt_d           = halt_q;
    err_d            = err_q;

    if (!bus.stall) begin
      case (state_q)
        FETCH: begin
          if (pc_q == HA) begin
            state_d = HALTED;
            halt_d  = 1'b1;
          end else begin
            state_d = EXEC;
          end
        end
        EXEC: begin
          state_d = FETCH;
          if (in_ds_q) begin
            // Delay slot retires: redirect; its own control is ignored
            pc_d            = pending_target_q;
            pending_valid_d = 1'b0;
            in_ds_d         = 1'b0;
          end else if (misaligned) begin
            state_d = HALTED;
            err_d   = 1'b1;
          end else begin
            pc_d = pc4;
            if (taken) begin
              pending_target_d = target;
              pending_valid_d  = 1'b1;
              in_ds_d          = 1'b1;
            end
          end
        end
        HALTED: ;
        default: state_d = HALTED;
      endcase
    end

    fetch_d = (state_d == FETCH);
    exec_d  = (state_d == EXEC);
  end

  assign bus.pc            = pc_q;
  assign bus.fetch         = fetch_q;
  assign bus.exec          = exec_q;
  assign bus.in_delay_slot = in_ds_q;
  assign bus.halt          = halt_q;
  assign bus.addr_error    = err_q;
  assign bus.link_addr     = pc_q + ADDR_W'(8);

endmodule
